// File: rtl/eth_phy_10g_hdr_err_gen.sv
// 66b sync-header error generator. Sits between PHY TX and PHY RX SerDes
// ports, forwards blocks through one register stage and corrupts sync
// headers at an LFSR-driven rate, optionally in bursts.
module eth_phy_10g_hdr_err_gen #(
  parameter int          DATA_WIDTH        = 64,
  parameter int          HDR_WIDTH         = 2,
  parameter logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  cfg_enable,
  input  logic [7:0]            cfg_err_rate,
  input  logic [7:0]            cfg_burst_len,
  input  logic [31:0]           cfg_block_count,
  input  logic [15:0]           cfg_seed,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic                  err_inject,
  output logic [31:0]           valid_count,
  output logic [31:0]           invalid_count,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BURST, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [7:0]            burst_q, burst_d;
  logic [31:0]           valid_q, valid_d;
  logic [31:0]           invalid_q, invalid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;

  logic [15:0]           seed_val;
  logic [15:0]           lfsr_step;
  logic [HDR_WIDTH-1:0]  bad_hdr;
  logic [7:0]            burst_m1;
  logic [32:0]           total_d;
  logic                  count_blk;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Seed selection, LFSR next value, corrupted header and burst reload value
  always_comb begin
    seed_val  = (cfg_seed == 16'd0) ? LFSR_DEFAULT_SEED : cfg_seed;
    lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // all-zero is a lock-up state; never let it be loaded
    if (lfsr_step == 16'd0) lfsr_step = seed_val;
    bad_hdr   = lfsr_q[8] ? {HDR_WIDTH{1'b1}} : {HDR_WIDTH{1'b0}};
    burst_m1  = (cfg_burst_len == 8'd0) ? 8'd0 : cfg_burst_len - 8'd1;
  end

  // Next-state, injection decision and counter updates
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    burst_d   = burst_q;
    valid_d   = valid_q;
    invalid_d = invalid_q;
    done_d    = done_q;
    err_d     = 1'b0;
    data_d    = in_data;
    hdr_d     = in_hdr;
    count_blk = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_enable) begin
          state_d   = S_RUN;
          valid_d   = 32'd0;
          invalid_d = 32'd0;
          done_d    = 1'b0;
          lfsr_d    = seed_val;
        end
      end
      S_RUN: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else begin
          count_blk = 1'b1;
          lfsr_d    = lfsr_step;
          if (lfsr_q[7:0] < cfg_err_rate) begin
            hdr_d     = bad_hdr;
            err_d     = 1'b1;
            invalid_d = sat_inc(invalid_q);
            burst_d   = burst_m1;
            if (burst_m1 != 8'd0) state_d = S_BURST;
          end else begin
            valid_d = sat_inc(valid_q);
          end
        end
      end
      S_BURST: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else begin
          count_blk = 1'b1;
          hdr_d     = bad_hdr;
          err_d     = 1'b1;
          invalid_d = sat_inc(invalid_q);
          burst_d   = (burst_q == 8'd0) ? 8'd0 : burst_q - 8'd1;
          if (burst_q <= 8'd1) state_d = S_RUN;
        end
      end
      default: begin
        if (!cfg_enable) state_d = S_IDLE;
      end
    endcase
    total_d = {1'b0, valid_d} + {1'b0, invalid_d};
    // block budget reached: stop, truncating any burst in flight
    if (count_blk && (cfg_block_count != 32'd0) && (total_d == {1'b0, cfg_block_count})) begin
      state_d = S_DONE;
      done_d  = 1'b1;
    end
  end

  // State, counters and the output register stage
  always_ff @(posedge tx_clk) begin
    if (!tx_rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= seed_val;
      burst_q   <= 8'd0;
      valid_q   <= 32'd0;
      invalid_q <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      hdr_q     <= HDR_WIDTH'(1);
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      burst_q   <= burst_d;
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      data_q    <= data_d;
      hdr_q     <= hdr_d;
    end
  end

  assign out_data      = data_q;
  assign out_hdr       = hdr_q;
  assign err_inject    = err_q;
  assign valid_count   = valid_q;
  assign invalid_count = invalid_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_BURST);
  assign done          = done_q;

endmodule

// File: tb/tb_eth_phy_10g_hdr_err_gen.sv
// Directed bench for the sync-header error generator.
module tb_eth_phy_10g_hdr_err_gen;
  localparam int DW = 64;

  logic          tx_clk = 1'b0;
  logic          tx_rst;
  logic [DW-1:0] in_data;
  logic [1:0]    in_hdr;
  logic          cfg_enable;
  logic [7:0]    cfg_err_rate;
  logic [7:0]    cfg_burst_len;
  logic [31:0]   cfg_block_count;
  logic [15:0]   cfg_seed;
  logic [DW-1:0] out_data;
  logic [1:0]    out_hdr;
  logic          err_inject;
  logic [31:0]   valid_count;
  logic [31:0]   invalid_count;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  eth_phy_10g_hdr_err_gen #(.DATA_WIDTH(DW), .HDR_WIDTH(2), .LFSR_DEFAULT_SEED(16'hACE1)) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .in_data(in_data), .in_hdr(in_hdr),
    .cfg_enable(cfg_enable), .cfg_err_rate(cfg_err_rate), .cfg_burst_len(cfg_burst_len),
    .cfg_block_count(cfg_block_count), .cfg_seed(cfg_seed),
    .out_data(out_data), .out_hdr(out_hdr), .err_inject(err_inject),
    .valid_count(valid_count), .invalid_count(invalid_count), .busy(busy), .done(done)
  );

  always #5 tx_clk = ~tx_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge tx_clk);
    #1;
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0
  function automatic logic [15:0] ref_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  task automatic go_idle;
    cfg_enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    tx_rst = 1'b0; cfg_enable = 1'b1; cfg_err_rate = 8'd255; cfg_burst_len = 8'd0;
    cfg_block_count = 32'd0; cfg_seed = 16'h0; in_data = 64'hDEAD_BEEF_0000_1111; in_hdr = 2'b10;
    tick(); tick();
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    checks++; if (out_hdr !== 2'b01) begin errors++; $display("FAIL reset_hdr: got %b expected 01", out_hdr); end
    checks++; if (err_inject !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_inject); end
    checks++; if (valid_count !== 32'd0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", valid_count); end
    checks++; if (invalid_count !== 32'd0) begin errors++; $display("FAIL reset_invalid: got %0d expected 0", invalid_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    cfg_enable = 1'b0;
    tx_rst = 1'b1;
    tick();
  endtask

  task automatic test_passthrough;
    cfg_enable = 1'b0; in_hdr = 2'b10; in_data = 64'h0707070707070707;
    tick();
    checks++; if (out_data !== 64'h0707070707070707) begin errors++; $display("FAIL pass_data: got %h expected 0707070707070707", out_data); end
    checks++; if (out_hdr !== 2'b10) begin errors++; $display("FAIL pass_hdr: got %b expected 10", out_hdr); end
    checks++; if (err_inject !== 1'b0) begin errors++; $display("FAIL pass_err: got %b expected 0", err_inject); end
    checks++; if (valid_count !== 32'd0 || invalid_count !== 32'd0) begin
      errors++; $display("FAIL pass_counts: got %0d/%0d expected 0/0", valid_count, invalid_count); end
  endtask

  task automatic test_no_errors;
    logic [DW-1:0] exp_d;
    logic [1:0]    exp_h;
    cfg_err_rate = 8'd0; cfg_burst_len = 8'd0; cfg_block_count = 32'd100; cfg_seed = 16'h0;
    cfg_enable = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      exp_d = {32'hA5A5_0000, 32'(i)};
      exp_h = i[0] ? 2'b10 : 2'b01;
      in_data = exp_d; in_hdr = exp_h;
      tick();
      checks++; if (out_data !== exp_d || out_hdr !== exp_h || err_inject !== 1'b0) begin
        errors++; $display("FAIL noerr_blk%0d: got %h/%b/%b expected %h/%b/0", i, out_data, out_hdr, err_inject, exp_d, exp_h); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL noerr_done: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noerr_busy: got %b expected 0", busy); end
    checks++; if (valid_count !== 32'd100) begin errors++; $display("FAIL noerr_valid: got %0d expected 100", valid_count); end
    checks++; if (invalid_count !== 32'd0) begin errors++; $display("FAIL noerr_invalid: got %0d expected 0", invalid_count); end
    go_idle();
  endtask

  task automatic rate_max_run(input int pass, output logic [31:0] vc, output logic [31:0] ic);
    logic [15:0] l;
    logic        e;
    int          exp_inv;
    l = 16'h1234; exp_inv = 0;
    cfg_enable = 1'b1; in_hdr = 2'b01;
    tick();
    checks++; if (valid_count !== 32'd0 || invalid_count !== 32'd0 || done !== 1'b0) begin
      errors++; $display("FAIL max%0d_clear: got %0d/%0d/%b expected 0/0/0", pass, valid_count, invalid_count, done); end
    for (int i = 0; i < 1000; i++) begin
      e = (l[7:0] != 8'hFF);
      if (e) exp_inv++;
      tick();
      checks++; if (err_inject !== e || out_hdr !== (e ? (l[8] ? 2'b11 : 2'b00) : 2'b01)) begin
        errors++; $display("FAIL max%0d_blk%0d: got err=%b hdr=%b expected err=%b lfsr=%h", pass, i, err_inject, out_hdr, e, l); end
      l = ref_step(l);
    end
    checks++; if (invalid_count !== 32'(exp_inv) || valid_count !== 32'(1000 - exp_inv)) begin
      errors++; $display("FAIL max%0d_counts: got %0d/%0d expected %0d/%0d", pass, valid_count, invalid_count, 1000 - exp_inv, exp_inv); end
    checks++; if (invalid_count < 32'd990 || invalid_count > 32'd1000 || valid_count + invalid_count !== 32'd1000) begin
      errors++; $display("FAIL max%0d_range: got inv=%0d total=%0d expected 990..1000, 1000", pass, invalid_count, valid_count + invalid_count); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL max%0d_done: got %b expected 1", pass, done); end
    vc = valid_count; ic = invalid_count;
    go_idle();
  endtask

  task automatic test_rate_max;
    logic [31:0] v1, i1, v2, i2;
    cfg_err_rate = 8'd255; cfg_burst_len = 8'd0; cfg_block_count = 32'd1000; cfg_seed = 16'h1234;
    rate_max_run(1, v1, i1);
    rate_max_run(2, v2, i2);
    checks++; if (v1 !== v2 || i1 !== i2) begin
      errors++; $display("FAIL max_repeat: got %0d/%0d expected %0d/%0d", v2, i2, v1, i1); end
  endtask

  // Seed 1234: decision byte 34 (<53 -> error, hdr 00); next two bytes 69, D2 pass
  task automatic test_burst;
    cfg_err_rate = 8'd53; cfg_burst_len = 8'd8; cfg_block_count = 32'd0; cfg_seed = 16'h1234;
    in_hdr = 2'b01; cfg_enable = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (err_inject !== (i < 8) || out_hdr !== ((i < 8) ? 2'b00 : 2'b01) || busy !== 1'b1) begin
        errors++; $display("FAIL burst_cyc%0d: got err=%b hdr=%b busy=%b expected err=%b", i, err_inject, out_hdr, busy, i < 8); end
    end
    checks++; if (invalid_count !== 32'd8 || valid_count !== 32'd2) begin
      errors++; $display("FAIL burst_counts: got %0d/%0d expected 2/8", valid_count, invalid_count); end
    cfg_enable = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || err_inject !== 1'b0) begin
      errors++; $display("FAIL burst_drop: got busy=%b err=%b expected 0/0", busy, err_inject); end
    tick();
    checks++; if (invalid_count !== 32'd8 || valid_count !== 32'd2) begin
      errors++; $display("FAIL burst_hold: got %0d/%0d expected 2/8", valid_count, invalid_count); end
  endtask

  task automatic test_burst_truncate;
    cfg_err_rate = 8'd53; cfg_burst_len = 8'd8; cfg_block_count = 32'd5; cfg_seed = 16'h1234;
    in_hdr = 2'b01; cfg_enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (err_inject !== 1'b1) begin errors++; $display("FAIL trunc_cyc%0d: got err=%b expected 1", i, err_inject); end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL trunc_done: got done=%b busy=%b expected 1/0", done, busy); end
    checks++; if (invalid_count !== 32'd5 || valid_count !== 32'd0) begin
      errors++; $display("FAIL trunc_counts: got %0d/%0d expected 0/5", valid_count, invalid_count); end
    tick();
    checks++; if (err_inject !== 1'b0 || out_hdr !== 2'b01 || invalid_count !== 32'd5) begin
      errors++; $display("FAIL trunc_after: got err=%b hdr=%b inv=%0d expected 0/01/5", err_inject, out_hdr, invalid_count); end
    go_idle();
  endtask

  task automatic test_reset_mid_burst;
    cfg_err_rate = 8'd53; cfg_burst_len = 8'd8; cfg_block_count = 32'd0; cfg_seed = 16'h1234;
    in_hdr = 2'b01; in_data = 64'h1122334455667788; cfg_enable = 1'b1;
    tick();
    tick(); tick(); tick();
    checks++; if (busy !== 1'b1 || err_inject !== 1'b1) begin
      errors++; $display("FAIL rmid_pre: got busy=%b err=%b expected 1/1", busy, err_inject); end
    tx_rst = 1'b0;
    tick();
    checks++; if (out_hdr !== 2'b01 || out_data !== 64'd0 || err_inject !== 1'b0) begin
      errors++; $display("FAIL rmid_out: got hdr=%b data=%h err=%b expected 01/0/0", out_hdr, out_data, err_inject); end
    checks++; if (valid_count !== 32'd0 || invalid_count !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rmid_state: got %0d/%0d busy=%b done=%b expected 0/0/0/0", valid_count, invalid_count, busy, done); end
    tx_rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b1 || err_inject !== 1'b0) begin
      errors++; $display("FAIL rmid_restart: got busy=%b err=%b expected 1/0", busy, err_inject); end
    tick();
    checks++; if (err_inject !== 1'b1 || out_hdr !== 2'b00 || invalid_count !== 32'd1) begin
      errors++; $display("FAIL rmid_first: got err=%b hdr=%b inv=%0d expected 1/00/1", err_inject, out_hdr, invalid_count); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_no_errors();
    test_rate_max();
    test_burst();
    test_burst_truncate();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_phy_10g_hdr_err_gen.md
Name: eth_phy_10g_hdr_err_gen

Overview:
- Synthesizable link-partner block that sits between the PHY transmit SerDes interface (serdes_tx_data/serdes_tx_hdr) and the PHY receive SerDes inputs (serdes_rx_data/serdes_rx_hdr).
- Forwards 66b blocks with a one-cycle register stage.
- Corrupts sync headers at a programmable, LFSR-driven rate, optionally in bursts, so the receiver's block-lock, BER-monitor and watchdog logic can be exercised deterministically in sim and on hardware.
- Counts good and corrupted blocks; stops after a programmable block count.

Parameters:
- DATA_WIDTH, 64, block payload width.
- HDR_WIDTH, 2, sync header width; the block supports only 2.
- LFSR_DEFAULT_SEED, 16'hACE1, seed used when cfg_seed is 0.

Ports:
- tx_clk  in  1  single clock for all logic.
- tx_rst  in  1  synchronous reset, active-low (0 = reset).
- in_data  in  DATA_WIDTH  block payload from PHY TX (serdes_tx_data).
- in_hdr  in  2  sync header from PHY TX (serdes_tx_hdr).
- cfg_enable  in  1  1 = run injection sequence; 0 = transparent pass-through.
- cfg_err_rate  in  8  error probability = cfg_err_rate/256 per decision.
- cfg_burst_len  in  8  corrupted blocks per error event; 0 is treated as 1.
- cfg_block_count  in  32  number of blocks to run; 0 = run forever.
- cfg_seed  in  16  LFSR seed, loaded on reset and on the IDLE->RUN transition.
- out_data  out  DATA_WIDTH  payload to PHY RX (serdes_rx_data).
- out_hdr  out  2  header to PHY RX (serdes_rx_hdr).
- err_inject  out  1  1 when the current out_hdr is corrupted.
- valid_count  out  32  blocks sent with the header unchanged.
- invalid_count  out  32  blocks sent with a corrupted header.
- busy  out  1  FSM is in RUN or BURST.
- done  out  1  cfg_block_count reached.

Behaviour:
- Reset (tx_rst=0 at a tx_clk edge): out_data=0, out_hdr=2'b01, err_inject=0, valid_count=0, invalid_count=0, busy=0, done=0, FSM=IDLE, LFSR=(cfg_seed==0 ? LFSR_DEFAULT_SEED : cfg_seed), burst counter=0. Reset overrides every other input and also aborts any sequence in progress.
- Latency: out_data/out_hdr reflect in_data/in_hdr from the previous cycle. The corruption decision applies to that same registered block.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts once per cycle in RUN only. It is never allowed to be 0; the seed is substituted as at reset.
- Corruption: the header is replaced by 2'b00 if lfsr[8]==0, else 2'b11. Data is never altered.
- FSM states:
  - IDLE: pass-through, err_inject=0, counters held. Move to RUN when cfg_enable=1; clear counters and done, and reload the LFSR.
  - RUN: each cycle, if lfsr[7:0] < cfg_err_rate, corrupt this block, increment invalid_count, load burst counter = max(cfg_burst_len,1)-1, and go to BURST if that value is >0. Otherwise forward unchanged and increment valid_count.
  - BURST: corrupt every block and decrement the burst counter. Return to RUN when it reaches 0 after this block. The LFSR holds in BURST.
  - DONE: pass-through, done=1, busy=0. Move to IDLE when cfg_enable=0.
- Block accounting: total = valid_count + invalid_count. When total reaches cfg_block_count (nonzero) at the end of a cycle, go to DONE from RUN or BURST; a burst is truncated.
- cfg_enable dropped in RUN or BURST: return to IDLE next cycle; counters hold their values.
- Counters saturate at 32'hFFFFFFFF. With cfg_block_count=0 there is no wrap.
- cfg_err_rate=0: never corrupt. cfg_err_rate=255: corrupt with probability 255/256.
- Config inputs are sampled live except cfg_seed (loaded at reset and on IDLE->RUN only) and cfg_burst_len (sampled at burst start).

Test Plan:
- cfg_err_rate=0, cfg_block_count=100, enable: out_hdr==in_hdr (delayed 1 cycle) on all blocks -> valid_count=100, invalid_count=0, done=1 in the cycle after the 100th block, busy=0.
- cfg_err_rate=255, cfg_burst_len=0, cfg_block_count=1000, cfg_seed=16'h1234: out_hdr is only ever 2'b00/2'b11 when err_inject=1 -> invalid_count within 990..1000, and valid_count+invalid_count=1000. A second run with the same seed gives identical counts.
- cfg_err_rate=255 with cfg_burst_len=8: the first error yields 8 consecutive err_inject=1 cycles. cfg_block_count=5 truncates this -> done with invalid_count=5.
- Pass-through: cfg_enable=0, drive in_hdr=2'b10 with in_data=64'h0707070707070707 -> identical out one cycle later, err_inject=0, counters stay 0.
- Reset mid-run: assert tx_rst=0 during BURST -> next cycle FSM=IDLE, all counters 0, out_hdr=2'b01. Releasing reset with cfg_enable=1 restarts the sequence cleanly.
- Receiver link: connect to eth_phy_10g with cfg_err_rate=8 (≈3%) -> rx_block_lock asserts, rx_status eventually 1. With cfg_err_rate=255 -> rx_block_lock deasserts and serdes_rx_bitslip pulses.
